// File: rtl/keypad_calc_core_if.sv
// Keypad calculator bus: debounced key strobe in, registered display value and status out.
// Latency: none, pure wiring bundle.
// Backpressure: none; key_valid is a one-cycle strobe with no ready.
interface keypad_calc_core_if #(
   parameter int WIDTH = 10
);
   logic             key_valid;
   logic [3:0]       key_code;
   logic [WIDTH-1:0] value_mag;
   logic             value_neg;
   logic             error;
   logic [2:0]       state;
   logic [1:0]       op_pending;

   // Key source side (keypad encoder / testbench)
   modport master (
      output key_valid, key_code,
      input  value_mag, value_neg, error, state, op_pending
   );

   // Calculator core side
   modport slave (
      input  key_valid, key_code,
      output value_mag, value_neg, error, state, op_pending
   );
endinterface

// File: rtl/keypad_calc_core.sv
// keypad_calc_core: operand/operator FSM turning keycodes into a sign/magnitude display value.
// Latency: key sampled at edge N appears on all registered outputs after edge N+1.
// Backpressure: none, every key_valid strobe is consumed; `define CALC_MUL_EN adds key 0xD multiply.
module keypad_calc_core #(
   parameter int WIDTH      = 10,
   parameter int MAX_DIGITS = 3
) (
   input logic               Clk,
   input logic               reset,
   keypad_calc_core_if.slave bus
);
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam int AW = 2 * WIDTH + 2;
   localparam logic [AW-1:0] MAX_MAG = {{(AW-WIDTH){1'b0}}, {WIDTH{1'b1}}};

   typedef enum logic [2:0] {
      ENTER_A = 3'd0,
      OP_WAIT = 3'd1,
      ENTER_B = 3'd2,
      RESULT  = 3'd3,
      ERROR   = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_ADD  = 2'b01,
      OP_SUB  = 2'b10,
      OP_MUL  = 2'b11
   } op_t;

   logic                  kv_q;
   logic [3:0]            kc_q;
   state_t                state_q, state_nxt;
   op_t                   op_q, op_nxt, key_op;
   logic signed [WIDTH:0] acc_a_q, acc_a_nxt;
   logic [WIDTH-1:0]      acc_b_q, acc_b_nxt;
   logic [WIDTH-1:0]      mag_q, mag_nxt;
   logic [CW-1:0]         cnt_q, cnt_nxt;
   logic                  error_q, error_nxt;
   logic                  neg_q, neg_nxt;
   logic                  is_digit, is_clear, is_equal, is_oper, cnt_ok, overflow;
   logic [AW-1:0]         digit_ext, new_a, new_b, res_abs;
   logic signed [AW-1:0]  a_ext, b_ext, res;

   // Key decode works on the registered key, giving the one-cycle latency
   assign is_digit = kv_q && (kc_q <= 4'd9);
   assign is_clear = kv_q && (kc_q == 4'hC);
   assign is_equal = kv_q && (kc_q == 4'hE);
`ifdef CALC_MUL_EN
   assign is_oper  = kv_q && ((kc_q == 4'hA) || (kc_q == 4'hB) || (kc_q == 4'hD));
`else
   assign is_oper  = kv_q && ((kc_q == 4'hA) || (kc_q == 4'hB));
`endif
   assign key_op   = (kc_q == 4'hA) ? OP_ADD : (kc_q == 4'hB) ? OP_SUB : OP_MUL;

   // Candidate operand values after appending the digit; acc_a is non-negative while entering it
   assign cnt_ok    = (int'(cnt_q) < MAX_DIGITS);
   assign digit_ext = AW'(kc_q);
   assign new_a     = AW'(acc_a_q[WIDTH-1:0]) * AW'(10) + digit_ext;
   assign new_b     = AW'(acc_b_q) * AW'(10) + digit_ext;

   // Wide signed arithmetic so the range check sees the true result
   assign a_ext = AW'(acc_a_q);
   assign b_ext = AW'(acc_b_q);

   // Select the pending operation's result
   always_comb begin
      res = a_ext;
      case (op_q)
         OP_ADD:  res = a_ext + b_ext;
         OP_SUB:  res = a_ext - b_ext;
`ifdef CALC_MUL_EN
         OP_MUL:  res = a_ext * b_ext;
`endif
         default: res = a_ext;
      endcase
   end

   assign res_abs  = res[AW-1] ? -res : res;
   assign overflow = (res_abs > MAX_MAG);

   // Next-state and register-update logic for the operand/operator FSM
   always_comb begin
      state_nxt = state_q;
      acc_a_nxt = acc_a_q;
      acc_b_nxt = acc_b_q;
      op_nxt    = op_q;
      cnt_nxt   = cnt_q;
      error_nxt = error_q;
      if (is_clear) begin
         state_nxt = ENTER_A;
         acc_a_nxt = '0;
         acc_b_nxt = '0;
         op_nxt    = OP_NONE;
         cnt_nxt   = '0;
         error_nxt = 1'b0;
      end else begin
         case (state_q)
            ENTER_A: begin
               if (is_digit && cnt_ok && (new_a <= MAX_MAG)) begin
                  acc_a_nxt = {1'b0, new_a[WIDTH-1:0]};
                  cnt_nxt   = cnt_q + CW'(1);
               end else if (is_oper) begin
                  op_nxt    = key_op;
                  cnt_nxt   = '0;
                  state_nxt = OP_WAIT;
               end
            end
            OP_WAIT: begin
               if (is_digit) begin
                  acc_b_nxt = digit_ext[WIDTH-1:0];
                  cnt_nxt   = CW'(1);
                  state_nxt = ENTER_B;
               end else if (is_oper) begin
                  op_nxt    = key_op;
               end
            end
            ENTER_B: begin
               if (is_digit && cnt_ok && (new_b <= MAX_MAG)) begin
                  acc_b_nxt = new_b[WIDTH-1:0];
                  cnt_nxt   = cnt_q + CW'(1);
               end else if (is_oper || is_equal) begin
                  if (overflow) begin
                     error_nxt = 1'b1;
                     state_nxt = ERROR;
                  end else begin
                     acc_a_nxt = res[WIDTH:0];
                     cnt_nxt   = '0;
                     state_nxt = is_oper ? OP_WAIT : RESULT;
                     if (is_oper) op_nxt = key_op;
                  end
               end
            end
            RESULT: begin
               if (is_digit) begin
                  acc_a_nxt = digit_ext[WIDTH:0];
                  cnt_nxt   = CW'(1);
                  state_nxt = ENTER_A;
               end else if (is_oper) begin
                  op_nxt    = key_op;
                  cnt_nxt   = '0;
                  state_nxt = OP_WAIT;
               end
            end
            ERROR:   state_nxt = ERROR;
            default: state_nxt = ENTER_A;
         endcase
      end
   end

   // Display value follows the next state so it is registered alongside it
   always_comb begin
      mag_nxt = '0;
      neg_nxt = 1'b0;
      if (state_nxt == ENTER_B) begin
         mag_nxt = acc_b_nxt;
      end else if (state_nxt != ERROR) begin
         neg_nxt = acc_a_nxt[WIDTH];
         mag_nxt = acc_a_nxt[WIDTH] ? WIDTH'(-acc_a_nxt) : WIDTH'(acc_a_nxt);
      end
   end

   // State register: key capture stage plus all FSM and output registers
   always_ff @(posedge Clk) begin
      if (reset) begin
         kv_q    <= 1'b0;
         kc_q    <= '0;
         state_q <= ENTER_A;
         acc_a_q <= '0;
         acc_b_q <= '0;
         op_q    <= OP_NONE;
         cnt_q   <= '0;
         error_q <= 1'b0;
         mag_q   <= '0;
         neg_q   <= 1'b0;
      end else begin
         kv_q    <= bus.key_valid;
         kc_q    <= bus.key_code;
         state_q <= state_nxt;
         acc_a_q <= acc_a_nxt;
         acc_b_q <= acc_b_nxt;
         op_q    <= op_nxt;
         cnt_q   <= cnt_nxt;
         error_q <= error_nxt;
         mag_q   <= mag_nxt;
         neg_q   <= neg_nxt;
      end
   end

   assign bus.value_mag  = mag_q;
   assign bus.value_neg  = neg_q;
   assign bus.error      = error_q;
   assign bus.state      = state_q;
   assign bus.op_pending = op_q;
endmodule

// File: tb/tb_keypad_calc_core.sv
// Testbench for keypad_calc_core: scoreboard of expected outputs fed by an integer calculator model.
// Latency: expects each key's effect one edge after the edge that samples it.
// Backpressure: none; keys may be issued back to back.
module tb_keypad_calc_core;
   localparam int WIDTH      = 10;
   localparam int MAX_DIGITS = 3;
   localparam int MAXV       = (1 << WIDTH) - 1;
`ifdef CALC_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct {
      int mag;
      bit neg;
      bit err;
      int st;
      int op;
   } exp_t;

   logic clk;
   logic reset;

   keypad_calc_core_if #(.WIDTH(WIDTH)) bus ();

   keypad_calc_core #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) dut (
      .Clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t sb_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   // Calculator model: plain integers; phase 0..4 follows the documented state numbering
   int m_a, m_b, m_cnt, m_ph, m_op;
   bit m_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string nm, input longint act, input longint exp_v);
      n_total++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
   endfunction

   function automatic void model_reset();
      m_a = 0; m_b = 0; m_cnt = 0; m_ph = 0; m_op = 0; m_err = 1'b0;
   endfunction

   function automatic exp_t model_view();
      exp_t e;
      e.err = m_err;
      e.st  = m_ph;
      e.op  = m_op;
      e.neg = 1'b0;
      e.mag = 0;
      if (m_ph == 2) e.mag = m_b;
      else if (m_ph != 4) begin
         e.neg = (m_a < 0);
         e.mag = (m_a < 0) ? -m_a : m_a;
      end
      return e;
   endfunction

   function automatic void model_key(input logic [3:0] c);
      int d, r, pick;
      bit is_op;
      d     = int'(c);
      is_op = (c == 4'hA) || (c == 4'hB) || (MUL_EN && (c == 4'hD));
      pick  = (c == 4'hA) ? 1 : (c == 4'hB) ? 2 : 3;
      if (c == 4'hC) begin
         model_reset();
      end else if (m_ph == 4) begin
         m_err = 1'b1;
      end else if (d <= 9) begin
         if (m_ph == 0 && m_cnt < MAX_DIGITS && m_a * 10 + d <= MAXV) begin
            m_a = m_a * 10 + d; m_cnt++;
         end else if (m_ph == 1) begin
            m_b = d; m_cnt = 1; m_ph = 2;
         end else if (m_ph == 2 && m_cnt < MAX_DIGITS && m_b * 10 + d <= MAXV) begin
            m_b = m_b * 10 + d; m_cnt++;
         end else if (m_ph == 3) begin
            m_a = d; m_cnt = 1; m_ph = 0;
         end
      end else if (is_op && m_ph != 2) begin
         m_op = pick; m_cnt = 0; m_ph = 1;
      end else if ((is_op || c == 4'hE) && m_ph == 2) begin
         r = (m_op == 1) ? m_a + m_b : (m_op == 2) ? m_a - m_b : (m_op == 3) ? m_a * m_b : m_a;
         if (r > MAXV || r < -MAXV) begin
            m_err = 1'b1; m_ph = 4;
         end else begin
            m_a = r; m_cnt = 0; m_ph = is_op ? 1 : 3;
            if (is_op) m_op = pick;
         end
      end
      sb_q.push_back(model_view());
   endfunction

   task automatic press(input logic [3:0] c, input bit b2b);
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_code  = c;
      model_key(c);
      if (!b2b) begin
         @(negedge clk);
         bus.key_valid = 1'b0;
         bus.key_code  = 4'($urandom);
      end
   endtask

   task automatic seq(input string s);
      int ch;
      logic [3:0] c;
      for (int i = 0; i < s.len(); i++) begin
         ch = int'(s.getc(i));
         c  = (ch <= 57) ? 4'(ch - 48) : 4'(ch - 55);
         press(c, 1'b0);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (sb_q.size() == 0) break;
         @(negedge clk);
      end
      check("scoreboard drained", sb_q.size(), 0);
   endtask

   task automatic expect_out(input string nm, input int mag, input int neg, input int err,
                             input int st, input int op);
      drain();
      check({nm, " value_mag"}, bus.value_mag, mag);
      check({nm, " value_neg"}, bus.value_neg, neg);
      check({nm, " error"}, bus.error, err);
      check({nm, " state"}, bus.state, st);
      check({nm, " op_pending"}, bus.op_pending, op);
   endtask

   // Monitor: a strobe sampled at one edge must be reflected after the following edge
   initial begin : monitor
      bit   v0, v1, ok;
      exp_t e;
      v0 = 1'b0;
      v1 = 1'b0;
      forever begin
         @(posedge clk);
         v1 = v0;
         v0 = bus.key_valid && !reset;
         #1;
         if (v1) begin
            n_total++;
            if (sb_q.size() == 0) begin
               $display("FAIL scoreboard: output for a key with no expected entry queued");
            end else begin
               e  = sb_q.pop_front();
               ok = (bus.value_mag == e.mag) && (bus.value_neg == e.neg) && (bus.error == e.err) &&
                    (int'(bus.state) == e.st) && (int'(bus.op_pending) == e.op);
               if (ok) n_pass++;
               else $display("FAIL scoreboard: got mag=%0d neg=%0d err=%0d st=%0d op=%0d, expected mag=%0d neg=%0d err=%0d st=%0d op=%0d",
                             bus.value_mag, bus.value_neg, bus.error, bus.state, bus.op_pending,
                             e.mag, e.neg, e.err, e.st, e.op);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int r;
      logic [3:0] c;
      reset         = 1'b1;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      expect_out("reset", 0, 0, 0, 0, 0);

      seq("1");      expect_out("first digit", 1, 0, 0, 0, 0);
      seq("23A");    expect_out("after add key", 123, 0, 0, 1, 1);
      seq("45E");    expect_out("123+45", 168, 0, 0, 3, 1);
      seq("5B9E");   expect_out("5-9", 4, 1, 0, 3, 2);
      seq("A10E");   expect_out("chain from negative", 6, 0, 0, 3, 1);
      seq("C9999");  expect_out("digit limit", 999, 0, 0, 0, 0);
      seq("A999E");  expect_out("overflow", 0, 0, 1, 4, 1);
      seq("3");      expect_out("key ignored in error", 0, 0, 1, 4, 1);
      seq("C");      expect_out("clear from error", 0, 0, 0, 0, 0);
      seq("2A3B");   expect_out("chain after sub key", 5, 0, 0, 1, 2);
      seq("1E");     expect_out("chain result", 4, 0, 0, 3, 2);
      seq("C7AB2E"); expect_out("operator replace", 5, 0, 0, 3, 2);

      // Back-to-back strobes: first key visible one edge later, second one edge after that
      seq("C");
      drain();
      press(4'h1, 1'b1);
      press(4'h2, 1'b0);
      check("b2b first key value_mag", bus.value_mag, 1);
      @(posedge clk);
      #1;
      check("b2b second key value_mag", bus.value_mag, 12);
      seq("C");
      press(4'h5, 1'b1);
      press(4'h5, 1'b0);
      expect_out("same code twice", 55, 0, 0, 0, 0);

`ifdef CALC_MUL_EN
      seq("C30D34E"); expect_out("30*34", 1020, 0, 0, 3, 3);
      seq("C32D32E"); expect_out("32*32 overflow", 0, 0, 1, 4, 3);
      seq("C2B5D4E"); expect_out("negative product", 12, 1, 0, 3, 3);
`else
      seq("C3D4");    expect_out("multiply key ignored", 34, 0, 0, 0, 0);
`endif

      // Reset on the same edge as a key strobe discards the key
      seq("C12A3");
      drain();
      @(negedge clk);
      reset         = 1'b1;
      bus.key_valid = 1'b1;
      bus.key_code  = 4'h5;
      @(negedge clk);
      reset         = 1'b0;
      bus.key_valid = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("reset+key value_mag", bus.value_mag, 0);
      check("reset+key value_neg", bus.value_neg, 0);
      check("reset+key error", bus.error, 0);
      check("reset+key state", bus.state, 0);
      check("reset+key op_pending", bus.op_pending, 0);

      // Randomised key stream against the model
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 55)      c = 4'($urandom_range(0, 9));
         else if (r < 68) c = 4'hA;
         else if (r < 78) c = 4'hB;
         else if (r < 84) c = 4'hD;
         else if (r < 92) c = 4'hE;
         else if (r < 96) c = 4'hC;
         else             c = 4'hF;
         press(c, (i != 399) && ($urandom_range(0, 2) == 0));
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/keypad_calc_core.md
# keypad_calc_core

Parametrised arithmetic core for the keypad calculator. It accepts debounced keycodes from the keypad encoder and assembles decimal operands digit by digit. It executes add/subtract (and optionally multiply) with chaining, and presents a registered sign/magnitude value for the binary-to-BCD and seven-segment path. It replaces the direct keycode-to-display connection with a real operand/operator state machine.

## Interface
- WIDTH, 10, magnitude width of operands and results in bits; max magnitude 2^WIDTH-1
- MAX_DIGITS, 3, maximum decimal digits accepted per operand
- Clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- key_valid  input  1  one-cycle strobe: key_code valid this cycle
- key_code  input  4  0x0-0x9 digit, 0xA add, 0xB subtract, 0xC clear, 0xD multiply (macro) else ignored, 0xE equals, 0xF ignored
- value_mag  output  WIDTH  magnitude of the value to display
- value_neg  output  1  sign of the displayed value (1 = negative)
- error  output  1  overflow latched; cleared only by clear key or reset
- state  output  3  current FSM state encoding (debug LEDs)
- op_pending  output  2  00 none, 01 add, 10 sub, 11 mul

## Operation
- Internal registers: acc_a (signed, WIDTH+1), acc_b (unsigned, WIDTH), op, digit_cnt, state.
- States: ENTER_A=0, OP_WAIT=1, ENTER_B=2, RESULT=3, ERROR=4.
- Digit entry: new = old*10 + d. Accepted only if digit_cnt < MAX_DIGITS and new <= 2^WIDTH-1; otherwise the key is silently ignored and no register changes. Leading zeros count as digits.
- ENTER_A: digit builds acc_a (from a non-negative value). An operator stores op and moves to OP_WAIT. Equals is ignored.
- OP_WAIT: a digit clears acc_b, enters it, and moves to ENTER_B. An operator replaces op. Equals is ignored.
- ENTER_B: digit builds acc_b. Equals computes acc_a op acc_b into acc_a and moves to RESULT. An operator computes the same way, stores the new op, and moves to OP_WAIT (chaining).
- RESULT: a digit clears acc_a, sets digit_cnt=0, enters the digit, and moves to ENTER_A. An operator keeps acc_a as the first operand and moves to OP_WAIT. Equals is ignored.
- Clear (0xC) in any state: acc_a=0, acc_b=0, op=none, digit_cnt=0, error=0, next state ENTER_A.
- Overflow: if |result| > 2^WIDTH-1, enter ERROR with error=1, value_mag=0, value_neg=0.
- ERROR: every key except clear is ignored.
- Display selection: ENTER_A, OP_WAIT and RESULT show |acc_a| with its sign; ENTER_B shows acc_b with value_neg=0.
- Arithmetic is performed at width 2*WIDTH+2 before the range check, so no wrap-around is ever visible.

## Timing
- Reset values: value_mag=0, value_neg=0, error=0, state=ENTER_A (0), op_pending=00. All internal registers are zero.
- A key sampled at edge N with key_valid=1 is reflected on all outputs after edge N+1 (one-cycle latency). All outputs are registered.
- Back-to-back key_valid strobes on consecutive cycles are each processed; no key is dropped.
- Each key_valid strobe is processed exactly once, even if key_code is held stable across strobes. key_code is ignored when key_valid=0.
- reset asserted mid-computation (same edge as key_valid) wins; the key is discarded.
- The operation completes in a single cycle; there is no busy handshake.

## Configuration
- CALC_MUL_EN defined: key 0xD is the multiply operator (op_pending=11). The product is range-checked exactly like add/sub, and a negative acc_a times acc_b gives a negative result.
- CALC_MUL_EN undefined: 0xD is ignored in every state, op_pending never equals 11, and no multiplier is synthesised.

## Test plan
- Reset, then keys 1,2,3,A,4,5,E: after the first key value_mag=1; after the A key value_mag=123 with op_pending=01; after the final key value_mag=168, state=3, value_neg=0.
- Keys 5,B,9,E: value_mag=4, value_neg=1. Then keys A,1,0,E: value_mag=6, value_neg=0 (chaining from a negative result).
- Digit limit: keys 9,9,9,9 give value_mag=999. Overflow: keys 9,9,9,A,9,9,9,E give error=1, state=4, value_mag=0. Then key 3 is ignored; key C gives error=0, state=0, value_mag=0.
- Chained operators: keys 2,A,3,B,1,E show 5 after the B key and 4 after E. Operator replacement: keys 7,A,B,2,E give value_mag=5.
- Timing: key_valid on consecutive cycles with codes 1,2 gives value_mag=12 two edges after the first strobe. Reset asserted together with a key strobe leaves all outputs at their reset values.
- CALC_MUL_EN: keys 3,0,D,3,4,E give value_mag=1020; keys 3,2,D,3,2,E give error=1. Without the macro, keys 3,D,4 give value_mag=34 and op_pending=00.
